// File: rtl/elevator_sched_if.sv
// elevator_sched_if
//   Connects the elevator car scheduler to its surroundings.
//   The master side drives the slow tick, the floor-call pulses and the door-close
//   button. The slave side (the scheduler) returns the car status.
//
//   tick     master -> slave  one-clk-wide timing enable from the clock divider
//   req      master -> slave  floor call pulses, bit i = floor i
//   close    master -> slave  debounced door-close button, level
//   floor    slave -> master  current car floor
//   dir      slave -> master  1 = up, 0 = down
//   door     slave -> master  1 = open, 0 = closed
//   moving   slave -> master  1 while the car travels between floors
//   arrived  slave -> master  one-clk pulse when the car stops at a serviced floor
//   pending  slave -> master  latched outstanding calls
interface elevator_sched_if;
   logic       tick;
   logic [7:0] req;
   logic       close;
   logic [2:0] floor;
   logic       dir;
   logic       door;
   logic       moving;
   logic       arrived;
   logic [7:0] pending;

   modport master (
      output tick, req, close,
      input  floor, dir, door, moving, arrived, pending
   );

   modport slave (
      input  tick, req, close,
      output floor, dir, door, moving, arrived, pending
   );
endinterface

// File: rtl/elevator_sched.sv
// elevator_sched
//   Car scheduler for an 8-floor elevator. Floor-call pulses are latched into a
//   pending mask. The car travels using SCAN: it keeps its direction while calls
//   remain ahead of it, and reverses only when none do. Floor-to-floor travel and
//   door dwell are timed in slow ticks. A call is cleared when the car arrives at
//   that floor.
//
//   Parameters
//     TRAVEL_TICKS  ticks per floor-to-floor move (>= 1)
//     DWELL_TICKS   ticks the door stays open at a serviced floor (>= 1)
//     CNT_W         counter width; must hold max(TRAVEL_TICKS, DWELL_TICKS)-1
//
//   Ports
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  slave side of elevator_sched_if (tick/req/close in, car status out)
module elevator_sched #(
   parameter int TRAVEL_TICKS = 4,
   parameter int DWELL_TICKS  = 6,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   elevator_sched_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      MOVE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_TICKS - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_TICKS - 1);

   state_t           state_q,   state_d;
   logic [2:0]       floor_q,   floor_d;
   logic             dir_q,     dir_d;
   logic             door_q,    door_d;
   logic             moving_q,  moving_d;
   logic             arrived_q, arrived_d;
   logic [7:0]       pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic       above, below;
   logic       dir_pick;
   logic [2:0] next_floor;
   logic       at_limit;
   logic [7:0] here_oh;
   logic [7:0] req_mask;
   logic [7:0] clr;

   // Outstanding calls strictly above / below the car, from the registered mask.
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (pending_q[i] && (3'(i) > floor_q)) above = 1'b1;
         if (pending_q[i] && (3'(i) < floor_q)) below = 1'b1;
      end
   end

   // SCAN: keep the current heading if anything lies ahead, otherwise reverse.
   assign dir_pick   = dir_q ? above : ~below;
   assign next_floor = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
   assign at_limit   = dir_q ? (floor_q == 3'd7) : (floor_q == 3'd0);
   assign here_oh    = 8'b1 << floor_q;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      door_d    = door_q;
      moving_d  = moving_q;
      arrived_d = 1'b0;
      cnt_d     = cnt_q;
      clr       = 8'b0;

      case (state_q)
         IDLE: begin
            door_d   = 1'b1;
            moving_d = 1'b0;
            if (bus.req[floor_q]) begin
               state_d = DWELL;
               cnt_d   = DWELL_LOAD;
            end else if (above || below) begin
               state_d  = MOVE;
               dir_d    = dir_pick;
               cnt_d    = TRAVEL_LOAD;
               door_d   = 1'b0;
               moving_d = 1'b1;
            end
         end

         DWELL: begin
            // A fresh call at this floor holds the door open and beats close/expiry.
            if (bus.req[floor_q]) begin
               cnt_d = DWELL_LOAD;
            end else if (bus.close || (bus.tick && (cnt_q == '0))) begin
               if (above || below) begin
                  state_d  = MOVE;
                  dir_d    = dir_pick;
                  cnt_d    = TRAVEL_LOAD;
                  door_d   = 1'b0;
                  moving_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         MOVE: begin
            if (bus.tick) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (at_limit) begin
                  // Cannot happen with a target always ahead; stop safely, never wrap.
                  state_d  = DWELL;
                  door_d   = 1'b1;
                  moving_d = 1'b0;
                  cnt_d    = DWELL_LOAD;
               end else begin
                  floor_d = next_floor;
                  cnt_d   = TRAVEL_LOAD;
                  if (pending_q[next_floor]) begin
                     clr       = 8'b1 << next_floor;
                     arrived_d = 1'b1;
                     door_d    = 1'b1;
                     moving_d  = 1'b0;
                     cnt_d     = DWELL_LOAD;
                     state_d   = DWELL;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // A call at the current floor is already being served while the door is open;
   // once the car is leaving, the same call must be remembered.
   assign req_mask  = (state_q == MOVE) ? 8'b0 : here_oh;
   assign pending_d = (pending_q | (bus.req & ~req_mask)) & ~clr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         floor_q   <= 3'd0;
         dir_q     <= 1'b1;
         door_q    <= 1'b1;
         moving_q  <= 1'b0;
         arrived_q <= 1'b0;
         pending_q <= 8'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         door_q    <= door_d;
         moving_q  <= moving_d;
         arrived_q <= arrived_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.floor   = floor_q;
   assign bus.dir     = dir_q;
   assign bus.door    = door_q;
   assign bus.moving  = moving_q;
   assign bus.arrived = arrived_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_elevator_sched.sv
// tb_elevator_sched
//   Directed bench for elevator_sched with TRAVEL_TICKS=4, DWELL_TICKS=6.
//   Each table record drives tick/close for n cycles, pulses req on the first
//   of them, then compares every output with the hand-derived expectation.
//   Hand-written sequences cover reset mid-move, call masking at an open door,
//   close-driven departure and clear-beats-request on an arrival cycle.
module tb_elevator_sched;

   typedef struct {
      int         n;
      logic       tick;
      logic [7:0] req;
      logic       close;
      logic [2:0] e_floor;
      logic       e_dir;
      logic       e_door;
      logic       e_moving;
      logic       e_arrived;
      logic [7:0] e_pending;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vq[$];

   elevator_sched_if bus ();

   elevator_sched #(
      .TRAVEL_TICKS (4),
      .DWELL_TICKS  (6),
      .CNT_W        (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] pack(input logic [2:0] f, input logic d, input logic dr,
                                        input logic m, input logic a, input logic [7:0] p);
      return {f, d, dr, m, a, p};
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] act;
      act = pack(bus.floor, bus.dir, bus.door, bus.moving, bus.arrived, bus.pending);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got floor=%0d dir=%b door=%b moving=%b arrived=%b pending=%b, want floor=%0d dir=%b door=%b moving=%b arrived=%b pending=%b",
                  name, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[14:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic add(input int n, input logic t, input logic [7:0] r, input logic c,
                      input logic [2:0] f, input logic d, input logic dr, input logic m,
                      input logic a, input logic [7:0] p);
      vec_t v;
      v.n = n; v.tick = t; v.req = r; v.close = c;
      v.e_floor = f; v.e_dir = d; v.e_door = dr; v.e_moving = m; v.e_arrived = a; v.e_pending = p;
      vq.push_back(v);
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic drive(input int n, input logic t, input logic [7:0] r, input logic c);
      for (int i = 0; i < n; i++) begin
         bus.tick  = t;
         bus.req   = (i == 0) ? r : 8'h00;
         bus.close = c;
         @(posedge clk);
         #1;
      end
      bus.tick  = 1'b0;
      bus.req   = 8'h00;
      bus.close = 1'b0;
   endtask

   initial begin
      //   n  tk req    cl | fl dir door mov arr pending
      // Call to floor 3 from floor 0.
      add( 1, 0, 8'h08, 0,  0, 1, 1, 0, 0, 8'h08);
      add( 1, 0, 8'h00, 0,  0, 1, 0, 1, 0, 8'h08);
      add( 3, 1, 8'h00, 0,  0, 1, 0, 1, 0, 8'h08);
      add( 1, 1, 8'h00, 0,  1, 1, 0, 1, 0, 8'h08);
      add( 4, 1, 8'h00, 0,  2, 1, 0, 1, 0, 8'h08);
      add( 3, 1, 8'h00, 0,  2, 1, 0, 1, 0, 8'h08);
      add( 1, 1, 8'h00, 0,  3, 1, 1, 0, 1, 8'h00);
      add( 1, 0, 8'h00, 0,  3, 1, 1, 0, 0, 8'h00);
      add( 5, 1, 8'h00, 0,  3, 1, 1, 0, 0, 8'h00);
      add( 1, 1, 8'h00, 0,  3, 1, 1, 0, 0, 8'h00);
      // SCAN: calls at 5 and 1 from floor 3 heading up; 5 first, then reverse to 1.
      add( 1, 0, 8'h20, 0,  3, 1, 1, 0, 0, 8'h20);
      add( 1, 0, 8'h00, 0,  3, 1, 0, 1, 0, 8'h20);
      add( 1, 1, 8'h02, 0,  3, 1, 0, 1, 0, 8'h22);
      add( 2, 1, 8'h00, 0,  3, 1, 0, 1, 0, 8'h22);
      add( 1, 1, 8'h00, 0,  4, 1, 0, 1, 0, 8'h22);
      add( 3, 1, 8'h00, 0,  4, 1, 0, 1, 0, 8'h22);
      add( 1, 1, 8'h00, 0,  5, 1, 1, 0, 1, 8'h02);
      add( 5, 1, 8'h00, 0,  5, 1, 1, 0, 0, 8'h02);
      add( 1, 1, 8'h00, 0,  5, 0, 0, 1, 0, 8'h02);
      add(15, 1, 8'h00, 0,  2, 0, 0, 1, 0, 8'h02);
      add( 1, 1, 8'h00, 0,  1, 0, 1, 0, 1, 8'h00);
      add( 6, 1, 8'h00, 0,  1, 0, 1, 0, 0, 8'h00);
      // Floor 2 from 1 (direction flips to up), then close cuts the dwell short.
      add( 1, 0, 8'h04, 0,  1, 0, 1, 0, 0, 8'h04);
      add( 1, 0, 8'h00, 0,  1, 1, 0, 1, 0, 8'h04);
      add( 4, 1, 8'h00, 0,  2, 1, 1, 0, 1, 8'h00);
      add( 1, 1, 8'h40, 0,  2, 1, 1, 0, 0, 8'h40);
      add( 1, 0, 8'h00, 1,  2, 1, 0, 1, 0, 8'h40);
      add(16, 1, 8'h00, 0,  6, 1, 1, 0, 1, 8'h00);
      // Call at the open-door floor plus close: reload wins, nothing latched.
      add( 1, 1, 8'h40, 1,  6, 1, 1, 0, 0, 8'h00);
      add( 1, 0, 8'h01, 0,  6, 1, 1, 0, 0, 8'h01);
      add( 5, 1, 8'h00, 0,  6, 1, 1, 0, 0, 8'h01);
      add( 1, 1, 8'h00, 0,  6, 0, 0, 1, 0, 8'h01);
      // Call at the departure floor is latched during MOVE and served after reversing.
      add( 1, 0, 8'h40, 0,  6, 0, 0, 1, 0, 8'h41);
      add(24, 1, 8'h00, 0,  0, 0, 1, 0, 1, 8'h40);
      add( 6, 1, 8'h00, 0,  0, 1, 0, 1, 0, 8'h40);
      add(12, 1, 8'h00, 0,  3, 1, 0, 1, 0, 8'h40);

      bus.tick  = 1'b0;
      bus.req   = 8'h00;
      bus.close = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset state", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
      rst = 1'b0;

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].n, vq[k].tick, vq[k].req, vq[k].close);
         check($sformatf("vec %0d", k),
               pack(vq[k].e_floor, vq[k].e_dir, vq[k].e_door, vq[k].e_moving,
                    vq[k].e_arrived, vq[k].e_pending));
      end

      // Reset while moving up at floor 3 with a call pending: everything drops to home.
      rst = 1'b1;
      drive(1, 1'b1, 8'h10, 1'b0);
      check("reset mid-move", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
      rst = 1'b0;

      drive(10, 1'b1, 8'h00, 1'b0);
      check("no motion after reset", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));

      // Call at the current floor with the door open is not latched.
      drive(1, 1'b0, 8'h01, 1'b0);
      check("own-floor call masked", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));

      drive(1, 1'b0, 8'h02, 1'b0);
      check("call latched in dwell", pack(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02));

      drive(1, 1'b0, 8'h00, 1'b1);
      check("close leaves dwell", pack(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02));

      drive(3, 1'b1, 8'h00, 1'b0);
      check("travel count", pack(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02));

      // Request for the arrival floor on the arrival edge: the clear wins.
      drive(1, 1'b1, 8'h02, 1'b0);
      check("clear beats req", pack(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00));

      drive(1, 1'b0, 8'h00, 1'b0);
      check("arrived one clk", pack(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/elevator_sched.md
Name: elevator_sched

Overview:
- Car scheduler for the 8-floor elevator.
- Latches floor-call pulses into a pending mask and tracks the car's current floor.
- Chooses travel direction with SCAN (keep going the same way while calls remain ahead).
- Times floor-to-floor travel and door dwell, and clears each call when the car arrives at that floor.
- Sits between the debounced button/switch inputs and the floor and door display logic, driven by the divided slow-tick enable.

Parameters:
TRAVEL_TICKS, 4, tick count per floor-to-floor move (min 1)
DWELL_TICKS, 6, tick count the door stays open at a serviced floor (min 1)
CNT_W, 4, width of the travel/dwell counter; must hold max(TRAVEL_TICKS, DWELL_TICKS)-1

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  reset, synchronous, active-high
tick  input  1  one-clk-wide timing enable from the clock divider
req  input  8  floor call pulses, bit i = floor i; multiple bits may be set
close  input  1  door-close button, debounced, level
floor  output  3  current car floor, registered
dir  output  1  1=up, 0=down, registered
door  output  1  1=open, 0=closed, registered
moving  output  1  1 while in MOVE
arrived  output  1  one-clk pulse when the car stops at a serviced floor
pending  output  8  latched outstanding calls

Behaviour:
- Reset values, applied on posedge clk with rst=1 and overriding everything else:
  - state=IDLE, floor=0, dir=1, door=1, moving=0, arrived=0, pending=0, counter=0.
  - Reset mid-move returns the car to floor 0 with no recovery of position.
- States:
  - IDLE: door open, no work.
  - DWELL: door open, counter running.
  - MOVE: door closed, counter running.
- Request latch, every cycle:
  - pending <= (pending | req_eff) & ~clr.
  - req_eff masks req[floor] when state is IDLE or DWELL; a call at the current floor with the door open is not latched.
  - During MOVE, req[floor] is latched because the car is leaving that floor.
  - clr is the one-hot of the arrival floor on an arrival cycle, else 0. Clear wins over a simultaneous req of the same bit.
- above = |(pending bits with index > floor); below = |(pending bits with index < floor). Both are computed from registered pending.
- Direction choice, made only when entering MOVE:
  - dir=1: above ? up : down.
  - dir=0: below ? down : up.
  - Entry to MOVE requires above|below=1, so the chosen direction always has a target.
- IDLE:
  - door=1.
  - If req[floor] is set: go to DWELL and load counter=DWELL_TICKS-1.
  - Else if above|below: choose dir, load counter=TRAVEL_TICKS-1, set door=0 and moving=1, go to MOVE. These take effect on the same clock edge.
  - close is ignored in IDLE.
- DWELL:
  - On tick, counter decrements.
  - req[floor] reloads counter=DWELL_TICKS-1. This has priority over close and expiry in the same cycle.
  - Exit condition: close=1, or (tick and counter==0).
  - On exit: if above|below, choose dir, load the travel count, door=0, go to MOVE; else go to IDLE.
- MOVE:
  - On tick with counter!=0, counter decrements.
  - On tick with counter==0: floor <= floor±1 per dir, and counter reloads TRAVEL_TICKS-1.
  - If pending[next floor] is set: clear it, pulse arrived, set door=1 and moving=0, load counter=DWELL_TICKS-1, go to DWELL.
  - Otherwise stay in MOVE.
  - close is ignored in MOVE.
- Bounds: floor never wraps. If dir=1 at floor 7 or dir=0 at floor 0 in MOVE (unreachable in legal operation), hold floor and go to DWELL with door=1.
- Timing: all outputs are registered. arrived is high for exactly the one clk following the arrival edge. Latency from a req pulse to pending set is 1 clk.

Test Plan:
- Reset, then req=8'b0000_1000 pulse at floor 0, TRAVEL_TICKS=4 -> MOVE next clk with dir=1, door=0. floor steps 1,2,3, one step every 4 ticks. At floor 3: arrived pulse, pending=0, door=1, then DWELL for 6 ticks, then IDLE.
- Car at floor 3 in MOVE up, pending={5,1} -> services 5 first (dir stays 1). After dwell, dir=0 and the car travels to floor 1; pending order of clears is bit5 then bit1.
- DWELL at floor 2, close=1 at dwell count 4 with pending bit6 set -> MOVE on the next clk with door=0, no waiting for the dwell to expire.
- DWELL at floor 4: req[4] pulse and close asserted in the same clk -> counter reloads to 5, door stays 1, pending[4] stays 0.
- MOVE leaving floor 2 upward, req[2] pulse -> pending[2]=1. After servicing the upper call, the car reverses and stops at 2.
- rst pulsed while in MOVE at floor 5 -> next clk floor=0, door=1, dir=1, pending=0, state IDLE. Tick activity after reset produces no motion until a new req.
